// File: rtl/ram_arbiter.sv
// ram_arbiter: shared single-port word RAM serving N cores, round-robin.
// Define RAM_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module ram_arbiter #(
  parameter int          N_CORES  = 4,
  parameter int          DEPTH    = 1024,
  parameter logic [2:0]  OP_LOAD  = 3'd1,
  parameter logic [2:0]  OP_STORE = 3'd2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3*N_CORES-1:0]    cpu_op,
  input  logic [32*N_CORES-1:0]   cpu_addr,
  input  logic [32*N_CORES-1:0]   cpu_wdata,
  output logic [32*N_CORES-1:0]   cpu_rdata,
  output logic [N_CORES-1:0]      cpu_ack
);

  localparam int IW = $clog2(N_CORES);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [N_CORES-1:0] pend_q, pend_d;
  logic [2:0]         op_q    [N_CORES];
  logic [2:0]         op_d    [N_CORES];
  logic [31:0]        addr_q  [N_CORES];
  logic [31:0]        addr_d  [N_CORES];
  logic [31:0]        wdata_q [N_CORES];
  logic [31:0]        wdata_d [N_CORES];
  logic [31:0]        out_q   [N_CORES];
  logic [31:0]        out_d   [N_CORES];

  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] pick;
  logic          pick_vld;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem [DEPTH];

  logic [2:0]    g_op;
  logic [31:0]   g_addr;
  logic [31:0]   g_wdata;
  logic [AW-1:0] g_idx;
  logic          g_in;
  logic          g_load;
  logic          g_store;
  logic          mem_we;
  logic          unused_ok;

  // Captured transaction of the currently granted core.
  assign g_op    = op_q[grant_q];
  assign g_addr  = addr_q[grant_q];
  assign g_wdata = wdata_q[grant_q];
  assign g_idx   = g_addr[AW+1:2];
  assign g_in    = (g_addr[31:AW+2] == '0);
  assign g_load  = (g_op == OP_LOAD);
  assign g_store = (g_op == OP_STORE);
  assign mem_we  = (state_q == ACCESS) && g_store && g_in;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign unused_ok = ^{g_addr[1:0], last_q};
`else
  assign unused_ok = ^g_addr[1:0];
`endif

  // Arbiter: first pending core in search order wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        pick     = IW'(i);
        pick_vld = 1'b1;
      end
    end
`else
    for (int k = N_CORES; k >= 1; k--) begin
      if (pend_q[(int'(last_q) + k) % N_CORES]) begin
        pick     = IW'((int'(last_q) + k) % N_CORES);
        pick_vld = 1'b1;
      end
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_vld) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ack pulse and read data steering in RESP.
  always_comb begin
    cpu_ack = '0;
    for (int i = 0; i < N_CORES; i++) begin
      cpu_rdata[32*i +: 32] = out_q[i];
      if (state_q == RESP && grant_q == IW'(i)) begin
        cpu_ack[i] = 1'b1;
        if (g_load) cpu_rdata[32*i +: 32] = rdata_q;
      end
    end
  end

  // Capture buffers, grant bookkeeping and load data path.
  always_comb begin
    pend_d  = pend_q;
    grant_d = grant_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    for (int i = 0; i < N_CORES; i++) begin
      op_d[i]    = op_q[i];
      addr_d[i]  = addr_q[i];
      wdata_d[i] = wdata_q[i];
      out_d[i]   = out_q[i];
      if ((cpu_op[3*i +: 3] == OP_LOAD ||
           cpu_op[3*i +: 3] == OP_STORE) &&
          !pend_q[i] && !cpu_ack[i]) begin
        pend_d[i]  = 1'b1;
        op_d[i]    = cpu_op[3*i +: 3];
        addr_d[i]  = cpu_addr[32*i +: 32];
        wdata_d[i] = cpu_wdata[32*i +: 32];
      end
    end
    if (state_q == IDLE && pick_vld) begin
      grant_d = pick;
      last_d  = pick;
    end
    if (state_q == ACCESS && g_load) begin
      rdata_d = g_in ? mem[g_idx] : '0;
    end
    if (state_q == RESP) begin
      pend_d[grant_q] = 1'b0;
      if (g_load) out_d[grant_q] = rdata_q;
    end
  end

  // Control and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      grant_q <= '0;
      last_q  <= IW'(N_CORES - 1);
      rdata_q <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      pend_q  <= pend_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < N_CORES; i++) begin
        out_q[i] <= out_d[i];
      end
    end
  end

  // Captured request fields need no reset; pend_q qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CORES; i++) begin
      op_q[i]    <= op_d[i];
      addr_q[i]  <= addr_d[i];
      wdata_q[i] <= wdata_d[i];
    end
  end

  // RAM write port; reset suppresses an in-flight store.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[g_idx] <= g_wdata;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter.
// Default build (round-robin), N_CORES=4, DEPTH=1024.
module tb_ram_arbiter;

  localparam int N = 4;
  localparam logic [2:0] LD = 3'd1;
  localparam logic [2:0] ST = 3'd2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3*N-1:0]  cpu_op = '0;
  logic [32*N-1:0] cpu_addr = '0;
  logic [32*N-1:0] cpu_wdata = '0;
  logic [32*N-1:0] cpu_rdata;
  logic [N-1:0]    cpu_ack;

  int checks = 0;
  int errors = 0;
  int multi = 0;
  int ack_cnt [N];
  int lat;
  int ack_at [N];
  logic [31:0] rd;
  logic [31:0] rd_at [N];
  int snap;

  ram_arbiter #(.N_CORES(N), .DEPTH(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_op    (cpu_op),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < N; i++) ack_cnt[i] = 0;

  always @(negedge clk) begin
    if (!$onehot0(cpu_ack)) multi++;
    for (int i = 0; i < N; i++) ack_cnt[i] += int'(cpu_ack[i]);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int c, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] d);
    cpu_op[3*c +: 3]     = op;
    cpu_addr[32*c +: 32] = a;
    cpu_wdata[32*c +: 32] = d;
  endtask

  // Issue one op at a negedge; keep it up through the ack cycle.
  task automatic txn(input int c, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] d,
                     output int l, output logic [31:0] r);
    set_op(c, op, a, d);
    l = -1;
    r = 'x;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (cpu_ack[c]) begin
        l = n;
        r = cpu_rdata[32*c +: 32];
        break;
      end
    end
    @(negedge clk);
    set_op(c, 3'd0, 32'h0, 32'h0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_ack", 32'(cpu_ack), 32'h0);
    chk("rst_rdata", 32'(|cpu_rdata), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: store then load, core 0
    txn(0, ST, 32'h10, 32'hDEADBEEF, lat, rd);
    chk("t1_st_lat", 32'(lat), 32'd3);
    chk("t1_rd_after_st", cpu_rdata[31:0], 32'h0);
    txn(0, LD, 32'h10, 32'h0, lat, rd);
    chk("t1_ld_lat", 32'(lat), 32'd3);
    chk("t1_ld_data", rd, 32'hDEADBEEF);

    // 2: four simultaneous loads after reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_op(i, LD, 32'h10, 32'h0);
      ack_at[i] = -1;
      rd_at[i] = '0;
    end
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ack_at[i] == n - 1) set_op(i, 3'd0, 32'h0, 32'h0);
        if (cpu_ack[i] && ack_at[i] < 0) begin
          ack_at[i] = n;
          rd_at[i] = cpu_rdata[32*i +: 32];
        end
      end
    end
    chk("t2_ack_c0", 32'(ack_at[0]), 32'd3);
    chk("t2_ack_c1", 32'(ack_at[1]), 32'd6);
    chk("t2_ack_c2", 32'(ack_at[2]), 32'd9);
    chk("t2_ack_c3", 32'(ack_at[3]), 32'd12);
    chk("t2_data_c3", rd_at[3], 32'hDEADBEEF);

    // 3: captured address stays put while core 1 wiggles it
    txn(0, ST, 32'h20, 32'h00001234, lat, rd);
    txn(0, ST, 32'h40, 32'h00004040, lat, rd);
    set_op(1, LD, 32'h20, 32'h0);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (cpu_ack[1]) begin
        lat = n;
        rd = cpu_rdata[63:32];
        break;
      end
      cpu_addr[63:32] = (n % 2 == 1) ? 32'h40 : 32'h44;
    end
    @(negedge clk);
    set_op(1, 3'd0, 32'h0, 32'h0);
    chk("t3_lat", 32'(lat), 32'd3);
    chk("t3_data", rd, 32'h00001234);

    // 4: out-of-range store and load, core 3
    txn(3, ST, 32'h0, 32'hA0A0A0A0, lat, rd);
    txn(3, ST, 32'h1000, 32'h00000BAD, lat, rd);
    chk("t4_oob_st_lat", 32'(lat), 32'd3);
    txn(3, LD, 32'h0, 32'h0, lat, rd);
    chk("t4_word0_kept", rd, 32'hA0A0A0A0);
    txn(3, LD, 32'h1000, 32'h0, lat, rd);
    chk("t4_oob_ld_lat", 32'(lat), 32'd3);
    chk("t4_oob_ld_data", rd, 32'h0);

    // 5: reset during ACCESS of a store
    txn(0, ST, 32'h8, 32'h00000011, lat, rd);
    set_op(0, ST, 32'h8, 32'h00000055);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_op(0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t5_ack_in_rst", 32'(cpu_ack), 32'h0);
    rst = 1'b0;
    snap = ack_cnt[0];
    repeat (5) @(negedge clk);
    chk("t5_no_ack_after", 32'(ack_cnt[0] - snap), 32'h0);
    set_op(0, LD, 32'h8, 32'h0);
    set_op(3, LD, 32'h10, 32'h0);
    for (int i = 0; i < N; i++) ack_at[i] = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      for (int i = 0; i < N; i = i + 3) begin
        if (ack_at[i] == n - 1) set_op(i, 3'd0, 32'h0, 32'h0);
        if (cpu_ack[i] && ack_at[i] < 0) begin
          ack_at[i] = n;
          rd_at[i] = cpu_rdata[32*i +: 32];
        end
      end
    end
    chk("t5_c0_first", 32'(ack_at[0]), 32'd3);
    chk("t5_c3_second", 32'(ack_at[3]), 32'd6);
    chk("t5_ram_kept", rd_at[0], 32'h00000011);

    // 6: back-to-back loads, core 2
    txn(2, ST, 32'h30, 32'hC0FFEE00, lat, rd);
    txn(2, ST, 32'h34, 32'h0BADF00D, lat, rd);
    txn(2, LD, 32'h30, 32'h0, lat, rd);
    chk("t6_ld1_lat", 32'(lat), 32'd3);
    chk("t6_ld1_data", rd, 32'hC0FFEE00);
    txn(2, LD, 32'h34, 32'h0, lat, rd);
    chk("t6_ld2_lat", 32'(lat), 32'd3);
    chk("t6_ld2_data", rd, 32'h0BADF00D);
    txn(2, ST, 32'h38, 32'h77777777, lat, rd);
    chk("t6_rd_hold", cpu_rdata[95:64], 32'h0BADF00D);
    snap = ack_cnt[2];
    repeat (10) @(negedge clk);
    chk("t6_no_extra_ack", 32'(ack_cnt[2] - snap), 32'h0);

    chk("onehot_ack", 32'(multi), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shared data-memory controller for a multicore cluster of sr_cpu cores.
- Accepts load/store requests from N cores on their AGU memory interfaces: op, byte address, store data.
- Serialises requests onto one internal single-port word RAM using round-robin arbitration.
- Returns read data and a one-cycle success pulse to each core; the core stalls until that pulse.

Parameters:
- N_CORES, 4, number of requesting cores (2..16).
- DEPTH, 1024, RAM depth in 32-bit words (power of 2).
- OP_LOAD, 3'd1, op code for load on cpu_op.
- OP_STORE, 3'd2, op code for store on cpu_op.
- Any other op value is idle.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_op  in  3*N_CORES  per-core memory op; core i uses bits [3i+2:3i].
- cpu_addr  in  32*N_CORES  per-core byte address.
- cpu_wdata  in  32*N_CORES  per-core store data.
- cpu_rdata  out  32*N_CORES  per-core load data.
- cpu_ack  out  N_CORES  per-core success pulse, drives the core's instrSuccess.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; all pending flags 0; cpu_ack=0; cpu_rdata=0; last_grant=N_CORES-1, so core 0 is granted first.
  - RAM contents are not cleared.
  - rst has priority over every other update. A store whose ACCESS cycle coincides with rst is not written.
- Per-core capture buffer:
  - Condition: op is LOAD/STORE, pending[i]=0, and cpu_ack[i]=0.
  - On that edge: capture op, addr and wdata; set pending[i].
  - Captured values are used for the whole transaction; later changes on the core's inputs are ignored. This is required because a stalled load rewrites rd every cycle, so a load like lw x5,0(x5) would otherwise change its own address.
  - pending[i] clears on the edge ending core i's RESP cycle.
- FSM (IDLE -> ACCESS -> RESP -> IDLE):
  - IDLE: if any pending bit is set, pick the first pending core searching from (last_grant+1) mod N_CORES upward with wrap; register grant and last_grant; go to ACCESS. Otherwise stay.
  - ACCESS: word index = captured addr[log2(DEPTH)+1:2]; addr[1:0] ignored.
    - Store: write the RAM.
    - Load: register RAM word into rdata_q.
    - Out-of-range (addr >= 4*DEPTH): store dropped, load returns 0.
    - Go to RESP.
  - RESP: cpu_ack[grant]=1 for exactly this cycle (decoded combinationally from state and grant). For loads, cpu_rdata[grant] = rdata_q. Go to IDLE.
- cpu_rdata[i] holds its last loaded value until core i's next load completes; stores do not alter it.
- Latency: op first visible in cycle 0 -> captured at end of cycle 0 -> IDLE arbitrates in cycle 1 -> ACCESS in cycle 2 -> ack in cycle 3. Minimum 4 cycles including cycle 0.
- Throughput: one access per 3 cycles.
- Worst-case wait for one core: 3*N_CORES cycles after capture (round-robin guarantees no starvation).
- At most one cpu_ack bit is high in any cycle.
- A core whose op returns to idle while its request is pending still completes. Its ack pulse is harmless because the core ignores instrSuccess when its op is idle.
- Back-to-back memory instructions from one core: the new op is visible in the cycle after ack, pending is 0, and it is captured as a new request.

Optional Feature:
- Macro RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index pending core always wins; last_grant is unused.
- Undefined (default): round-robin as above.
- Everything else is identical in both builds.

Test Plan:
1. Single store then load, core 0 only:
   - Stimulus: store 0xDEADBEEF to addr 0x10; after its ack, load 0x10.
   - Required: each ack arrives in cycle 3 after its op appears; cpu_rdata[0]=0xDEADBEEF during the load ack.
2. Simultaneous loads, 4 cores, round-robin:
   - Stimulus: all cores issue loads in the same cycle after reset.
   - Required: acks in order core 0,1,2,3, 3 cycles apart; no two acks in one cycle.
   - With RAM_ARB_FIXED_PRIO_EN and core 0 re-requesting immediately after each ack: core 0 is served repeatedly ahead of cores 1-3.
3. Captured-address stability:
   - Stimulus: core 1 loads addr 0x20 (RAM=0x1234) while the bench changes cpu_addr[1] to 0x40 every cycle during the stall.
   - Required: cpu_rdata[1]=0x1234.
4. Out-of-range access, DEPTH=1024:
   - Store to 0x1000 -> acked, RAM unchanged.
   - Load from 0x1000 -> acked with data 0.
5. Reset mid-operation:
   - Stimulus: assert rst during ACCESS of a store of 0x55 to 0x8 (RAM[2] previously 0x11).
   - Required: RAM[2] still 0x11; no ack; all pending flags 0; next request is granted to core 0 first.
6. Back-to-back loads, core 2:
   - Stimulus: load then load with a different address.
   - Required: two separate acks, each for the correct address; no double capture in the ack cycle.
